// File: rtl/uop_pair_sequencer.sv
// Splits two-micro-op instructions (HI/LO multiply/divide family) into a back-to-back
// uop pair for decode; single-uop instructions pass straight through one per cycle.
module uop_pair_sequencer #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              in_is_double,
    input  logic              in_ex,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_is_inst2,
    output logic              out_ex,
    output logic              out_int_allow,
    output logic [CNT_W-1:0]  pair_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [PC_W-1:0]     pc_r;
    logic [INST_W-1:0]   inst_r;
    logic                double_r;
    logic                ex_r;
    logic [CNT_W-1:0]    pair_cnt_r;
    logic                in_ready_s;
    logic                in_fire_s;
    logic                out_fire_s;
    logic                load_s;
    logic                pair_inc_s;

    // Handshake qualifiers; a held double blocks intake while its uop0 is presented.
    always_comb begin
        in_ready_s = 1'b0;
        if (resetn && !flush) begin
            case (state_r)
                ST_EMPTY:  in_ready_s = 1'b1;
                ST_FIRST:  in_ready_s = !double_r && out_ready;
                ST_SECOND: in_ready_s = out_ready;
                default:   in_ready_s = 1'b0;
            endcase
        end else begin
            in_ready_s = 1'b0;
        end
        in_fire_s  = in_valid && in_ready_s;
        out_fire_s = (state_r != ST_EMPTY) && out_ready;
    end

    // Next-state, entry-load and pair-count decisions.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        pair_inc_s  = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s = ST_FIRST;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FIRST: begin
                    // A faulting double retires as a single: only uop0 carries the fault.
                    if (!out_fire_s) begin
                        state_nxt_s = ST_FIRST;
                    end else if (double_r && !ex_r) begin
                        state_nxt_s = ST_SECOND;
                    end else if (in_fire_s) begin
                        state_nxt_s = ST_FIRST;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_SECOND: begin
                    if (!out_fire_s) begin
                        state_nxt_s = ST_SECOND;
                    end else if (in_fire_s) begin
                        pair_inc_s  = 1'b1;
                        state_nxt_s = ST_FIRST;
                        load_s      = 1'b1;
                    end else begin
                        pair_inc_s  = 1'b1;
                        state_nxt_s = ST_EMPTY;
                    end
                end
                default: state_nxt_s = ST_EMPTY;
            endcase
        end
    end

    // State, held entry and pair counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_EMPTY;
            pc_r       <= {PC_W{1'b0}};
            inst_r     <= {INST_W{1'b0}};
            double_r   <= 1'b0;
            ex_r       <= 1'b0;
            pair_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (load_s) begin
                pc_r     <= in_pc;
                inst_r   <= in_inst;
                double_r <= in_is_double;
                ex_r     <= in_ex;
            end
            if (pair_inc_s) begin
                pair_cnt_r <= pair_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_ready      = in_ready_s;
    assign out_valid     = (state_r != ST_EMPTY);
    assign out_pc        = pc_r;
    assign out_inst      = inst_r;
    assign out_is_inst2  = (state_r == ST_SECOND);
    assign out_ex        = ex_r && (state_r != ST_SECOND);
    assign out_int_allow = (state_r == ST_FIRST);
    assign pair_cnt      = pair_cnt_r;

endmodule
